fpu_issue_sched: RTL and testbench

Issue scheduler for the multi-cycle FPU in the pipelined CPU core. It sits between the decode-stage controller and the FPU. It decides whether a decoded float instruction may issue this cycle, checking three hazards: source busy (RAW), destination busy (WAW), and writeback-port collision. It tracks in-flight float results and retires them through a single register-file write port with a one-hot retirement schedule. It replaces fixed stall counting with per-register scoreboarding.

---
 rtl/fpu_issue_sched.sv | 144 ++++++++++++++
 tb/tb_fpu_issue_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_sched.sv
// Issue scheduler for the multi-cycle FPU: RAW/WAW/writeback-port hazard check plus a retirement shift schedule.
// Latency: grant is combinational in the request cycle; a tracked result retires (wb_valid) exactly lat cycles later.
// Backpressure: a hazarded request is held off via stall; in-flight results always retire and are never stalled or flushed.
module fpu_issue_sched #(
  parameter int NREG    = 32,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [LAT_W-1:0] lat,
  input  logic [REG_W-1:0] dst,
  input  logic             wr_dst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             use_src2,
  input  logic             flush,
  output logic             grant,
  output logic             stall,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_reg,
  output logic [NREG-1:0]  busy_vec,
  output logic [LAT_W:0]   inflight
);

  // Slot k holds an entry that retires k cycles from now; the wb register acts as slot 0.
  logic [NREG-1:0]  busy_q, busy_d;
  logic [LAT_W:0]   inflight_q, inflight_d;
  logic [MAX_LAT:1] slot_vld_q, slot_vld_d;
  logic [REG_W-1:0] slot_tag_q [1:MAX_LAT];
  logic [REG_W-1:0] slot_tag_d [1:MAX_LAT];
  logic             wb_valid_q, wb_valid_d;
  logic [REG_W-1:0] wb_reg_q, wb_reg_d;

  logic [MAX_LAT:1] merged_vld;
  logic [REG_W-1:0] merged_tag [1:MAX_LAT];
  logic [MAX_LAT:0] slot_ahead;
  logic             raw1, raw2, waw, port_hit, hazard, track;
  logic             dup_tag;

  // Index 0 is never occupied, so lat=0 can never report a port collision.
  assign slot_ahead = {slot_vld_q, 1'b0};

  assign raw1     = use_src1 & busy_q[src1];
  assign raw2     = use_src2 & busy_q[src2];
  assign waw      = wr_dst & busy_q[dst];
  assign port_hit = wr_dst & slot_ahead[lat];
  assign hazard   = raw1 | raw2 | waw | port_hit;

  assign grant = req & ~flush & ~hazard;
  assign stall = req & ~flush & ~grant;
  // Only ops with a multi-cycle result and a real destination occupy the write port.
  assign track = grant & wr_dst & (lat != '0);

  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign busy_vec = busy_q;
  assign inflight = inflight_q;

  // Merge the new entry into its slot, then advance the whole schedule by one cycle.
  always_comb begin
    merged_vld = slot_vld_q;
    for (int k = 1; k <= MAX_LAT; k++) begin
      merged_tag[k] = slot_tag_q[k];
      if (track && (lat == LAT_W'(k))) begin
        merged_vld[k] = 1'b1;
        merged_tag[k] = dst;
      end
    end
    slot_vld_d = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      slot_tag_d[k] = '0;
    end
    for (int k = 1; k < MAX_LAT; k++) begin
      slot_vld_d[k] = merged_vld[k+1];
      slot_tag_d[k] = merged_tag[k+1];
    end
    wb_valid_d = merged_vld[1];
    wb_reg_d   = merged_vld[1] ? merged_tag[1] : '0;
  end

  // Scoreboard: a retiring register stays busy through its wb cycle, then clears; a tracked grant sets dst.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_q) begin
      busy_d[wb_reg_q] = 1'b0;
    end
    if (track) begin
      busy_d[dst] = 1'b1;
    end
    case ({track, wb_valid_q})
      2'b10:   inflight_d = inflight_q + (LAT_W+1)'(1);
      2'b01:   inflight_d = inflight_q - (LAT_W+1)'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset discards every pending retirement.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      inflight_q <= '0;
      slot_vld_q <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        slot_tag_q[k] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      slot_vld_q <= slot_vld_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      for (int k = 1; k <= MAX_LAT; k++) begin
        slot_tag_q[k] <= slot_tag_d[k];
      end
    end
  end

  // A register may have at most one pending entry anywhere in the schedule.
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (slot_vld_q[i] && wb_valid_q && (slot_tag_q[i] == wb_reg_q)) dup_tag = 1'b1;
      for (int j = i + 1; j <= MAX_LAT; j++) begin
        if (slot_vld_q[i] && slot_vld_q[j] && (slot_tag_q[i] == slot_tag_q[j])) dup_tag = 1'b1;
      end
    end
  end

  // Consistency checks between scoreboard, counter and schedule.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!dup_tag);
      assert ($countones(busy_q) == int'(inflight_q));
      assert (int'(inflight_q) <= MAX_LAT);
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Randomized and directed bench for fpu_issue_sched with a cycle-level reference model and scoreboard.
// Latency: one expectation per cycle, checked half a cycle after the inputs are driven.
// Backpressure: none applied to the bench; stalled requests are simply re-presented by the stimulus.
module tb_fpu_issue_sched;
  localparam int NREG    = 32;
  localparam int REG_W   = 5;
  localparam int LAT_W   = 3;
  localparam int MAX_LAT = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req = 1'b0;
  logic [LAT_W-1:0] lat = '0;
  logic [REG_W-1:0] dst = '0;
  logic             wr_dst = 1'b0;
  logic [REG_W-1:0] src1 = '0;
  logic [REG_W-1:0] src2 = '0;
  logic             use_src1 = 1'b0;
  logic             use_src2 = 1'b0;
  logic             flush = 1'b0;
  logic             grant, stall, wb_valid;
  logic [REG_W-1:0] wb_reg;
  logic [NREG-1:0]  busy_vec;
  logic [LAT_W:0]   inflight;

  always #5 clk = ~clk;

  fpu_issue_sched #(.NREG(NREG), .REG_W(REG_W), .LAT_W(LAT_W), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .lat(lat), .dst(dst), .wr_dst(wr_dst),
    .src1(src1), .src2(src2), .use_src1(use_src1), .use_src2(use_src2), .flush(flush),
    .grant(grant), .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .busy_vec(busy_vec), .inflight(inflight)
  );

  typedef struct {
    int          cyc;
    bit          chk;
    bit          post_rst;
    bit          grant;
    bit          stall;
    logic [31:0] busy;
    int          inflight;
  } exp_t;

  typedef struct {
    int cyc;
    int r;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];
  int   retire_at[NREG];   // cycle in which register r retires, -1 if nothing pending
  int   cyc = 0;
  bit   last_rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic bit m_busy(int r);
    return retire_at[r] >= cyc;
  endfunction

  function automatic bit m_port_taken(int c);
    for (int r = 0; r < NREG; r++) if (retire_at[r] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string name, int c, longint act, longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, expv);
  endtask

  // Drive one cycle of inputs, record the expected outputs, then advance the model.
  task automatic step(bit rst, bit rq, int l, int d, bit wd, int s1, int s2, bit u1, bit u2, bit fl, bit chk);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    reset = rst; req = rq; lat = LAT_W'(l); dst = REG_W'(d); wr_dst = wd;
    src1 = REG_W'(s1); src2 = REG_W'(s2); use_src1 = u1; use_src2 = u2; flush = fl;
    hz = (u1 && m_busy(s1)) || (u2 && m_busy(s2)) || (wd && m_busy(d)) ||
         (l >= 1 && wd && m_port_taken(cyc + l));
    e.cyc = cyc; e.chk = chk; e.post_rst = last_rst;
    e.grant = rq && !fl && !hz;
    e.stall = rq && !fl && !e.grant;
    e.busy = '0;
    e.inflight = 0;
    for (int r = 0; r < NREG; r++) if (m_busy(r)) begin
      e.busy[r] = 1'b1;
      e.inflight++;
    end
    exp_q.push_back(e);
    if (rst) begin
      // Results retiring in this very cycle still appear; everything later is discarded.
      wb_t keep[$];
      for (int r = 0; r < NREG; r++) if (retire_at[r] > cyc) retire_at[r] = -1;
      foreach (wb_q[i]) if (wb_q[i].cyc <= cyc) keep.push_back(wb_q[i]);
      wb_q = keep;
    end else if (e.grant && l >= 1 && wd) begin
      wb_t w;
      int  pos;
      retire_at[d] = cyc + l;
      w.cyc = cyc + l; w.r = d;
      pos = wb_q.size();
      foreach (wb_q[i]) if (wb_q[i].cyc > w.cyc && pos == wb_q.size()) pos = i;
      wb_q.insert(pos, w);
    end
    last_rst = rst;
    cyc++;
  endtask

  task automatic op(int l, int d, bit wd, int s1, bit u1);
    step(0, 1, l, d, wd, s1, 0, u1, 0, 0, 1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation and the retirement scoreboard.
  initial begin
    exp_t e;
    bit   exp_wb;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("grant", e.cyc, grant, e.grant);
          check("stall", e.cyc, stall, e.stall);
          check("busy_vec", e.cyc, busy_vec, e.busy);
          check("inflight", e.cyc, inflight, e.inflight);
          exp_wb = (wb_q.size() > 0) && (wb_q[0].cyc == e.cyc);
          check("wb_valid", e.cyc, wb_valid, exp_wb);
          if (exp_wb) begin
            if (wb_valid) check("wb_reg", e.cyc, wb_reg, wb_q[0].r);
            void'(wb_q.pop_front());
          end
          if (e.post_rst) check("wb_reg_after_reset", e.cyc, wb_reg, 0);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < NREG; r++) retire_at[r] = -1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset state, then single op lat=3 dst=4.
    op(3, 4, 1, 0, 0);
    idle(6);
    // RAW: dependent lat=1 op held until register 4 frees.
    op(3, 4, 1, 0, 0);
    for (int i = 0; i < 4; i++) op(1, 9, 1, 4, 1);
    idle(6);
    // Writeback-port collision.
    op(4, 1, 1, 0, 0);
    op(3, 2, 1, 0, 0);
    op(3, 2, 1, 0, 0);
    idle(8);
    // WAW against a lat=0 op, then an independent lat=0 op.
    op(5, 7, 1, 0, 0);
    for (int i = 0; i < 6; i++) op(0, 7, 1, 0, 0);
    idle(6);
    op(5, 7, 1, 0, 0);
    op(0, 8, 1, 0, 0);
    op(4, 3, 0, 0, 0);
    idle(8);
    // Flush with no hazard, then flush with three ops in flight.
    step(0, 1, 2, 5, 1, 0, 0, 0, 0, 1, 1);
    op(5, 10, 1, 0, 0);
    op(5, 11, 1, 0, 0);
    op(5, 12, 1, 0, 0);
    step(0, 1, 1, 13, 1, 0, 0, 0, 0, 1, 1);
    idle(8);
    // Reset mid-flight, then a fresh op.
    op(7, 20, 1, 0, 0);
    op(7, 21, 1, 0, 0);
    op(7, 22, 1, 0, 0);
    do_reset();
    op(2, 3, 1, 0, 0);
    idle(10);
    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      int  hi;
      bit  rst;
      hi  = ($urandom_range(0, 7) == 0) ? 31 : 7;
      rst = ($urandom_range(0, 99) == 0);
      step(rst, ($urandom_range(0, 3) != 0), $urandom_range(0, MAX_LAT),
           $urandom_range(0, hi), ($urandom_range(0, 4) != 0),
           $urandom_range(0, hi), $urandom_range(0, hi),
           $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0), 1);
    end
    idle(12);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("wb_queue_drained", cyc, wb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
